// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: display codes,
// active-low segment patterns {g,f,e,d,c,b,a} and the slot state type.
package seg_pkg;

  localparam logic [3:0] CODE_R = 4'hA;
  localparam logic [3:0] CODE_D = 4'hB;
  localparam logic [3:0] CODE_Y = 4'hC;
  localparam logic [3:0] CODE_E = 4'hD;
  localparam logic [3:0] CODE_T = 4'hE;
  localparam logic [3:0] CODE_O = 4'hF;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_PAT_0 = 7'h40;
  localparam logic [6:0] SEG_PAT_1 = 7'h79;
  localparam logic [6:0] SEG_PAT_2 = 7'h24;
  localparam logic [6:0] SEG_PAT_3 = 7'h30;
  localparam logic [6:0] SEG_PAT_4 = 7'h19;
  localparam logic [6:0] SEG_PAT_5 = 7'h12;
  localparam logic [6:0] SEG_PAT_6 = 7'h02;
  localparam logic [6:0] SEG_PAT_7 = 7'h78;
  localparam logic [6:0] SEG_PAT_8 = 7'h00;
  localparam logic [6:0] SEG_PAT_9 = 7'h10;
  localparam logic [6:0] SEG_PAT_R = 7'h2F;
  localparam logic [6:0] SEG_PAT_D = 7'h21;
  localparam logic [6:0] SEG_PAT_Y = 7'h11;
  localparam logic [6:0] SEG_PAT_E = 7'h06;
  localparam logic [6:0] SEG_PAT_T = 7'h07;
  localparam logic [6:0] SEG_PAT_O = 7'h23;

  typedef enum logic {
    SLOT_GUARD = 1'b0,
    SLOT_SHOW  = 1'b1
  } slot_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit display code to active-low seven-segment pattern.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  // code lookup
  always_comb begin
    seg_o = SEG_OFF;
    case (code_i)
      4'h0:   seg_o = SEG_PAT_0;
      4'h1:   seg_o = SEG_PAT_1;
      4'h2:   seg_o = SEG_PAT_2;
      4'h3:   seg_o = SEG_PAT_3;
      4'h4:   seg_o = SEG_PAT_4;
      4'h5:   seg_o = SEG_PAT_5;
      4'h6:   seg_o = SEG_PAT_6;
      4'h7:   seg_o = SEG_PAT_7;
      4'h8:   seg_o = SEG_PAT_8;
      4'h9:   seg_o = SEG_PAT_9;
      CODE_R: seg_o = SEG_PAT_R;
      CODE_D: seg_o = SEG_PAT_D;
      CODE_Y: seg_o = SEG_PAT_Y;
      CODE_E: seg_o = SEG_PAT_E;
      CODE_T: seg_o = SEG_PAT_T;
      CODE_O: seg_o = SEG_PAT_O;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with per-frame input snapshot.
// Optional SEG_BLINK_EN adds a blink port and a free-running blink phase.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_DIV   = 25000000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  input  logic [3:0] blank,
`ifdef SEG_BLINK_EN
  input  logic [3:0] blink,
`endif
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    a_q, b_q, c_q, d_q, blank_q;
  logic [3:0]    a_d, b_d, c_d, d_d, blank_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_q, frame_d;
  logic          snap_s;
  logic [3:0]    code_s;
  logic [6:0]    pat_s;
  logic [3:0]    hide_s;
  slot_e         slot_s;

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] bcnt_q;
  logic          ph_q;
  logic [3:0]    blink_q;

  // blink phase generator and blink mask latch
  always_ff @(posedge clk) begin
    if (!reset) begin
      bcnt_q  <= '0;
      ph_q    <= 1'b0;
      blink_q <= 4'h0;
    end else begin
      if (bcnt_q == BW'(BLINK_DIV - 1)) begin
        bcnt_q <= '0;
        ph_q   <= ~ph_q;
      end else begin
        bcnt_q <= bcnt_q + BW'(1);
      end
      if (snap_s) blink_q <= blink;
    end
  end

  assign hide_s = blank_q | (ph_q ? blink_q : 4'h0);
`else
  assign hide_s = blank_q;
`endif

  seg7_decode u_dec (
    .code_i (code_s),
    .seg_o  (pat_s)
  );

  // Snapshot at the start of every frame; reset leaves cnt/idx at 0 so the
  // first cycle after release also snapshots.
  always_comb begin
    snap_s  = (cnt_q == '0) && (idx_q == 2'd0);
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    idx_d   = (cnt_q == CNT_LAST) ? idx_q + 2'd1 : idx_q;
    a_d     = snap_s ? A     : a_q;
    b_d     = snap_s ? B     : b_q;
    c_d     = snap_s ? C     : c_q;
    d_d     = snap_s ? D     : d_q;
    blank_d = snap_s ? blank : blank_q;
    frame_d = snap_s;
    slot_s  = (cnt_q < CNT_GUARD) ? SLOT_GUARD : SLOT_SHOW;
    code_s  = a_q;
    case (idx_q)
      2'd0:    code_s = a_q;
      2'd1:    code_s = b_q;
      2'd2:    code_s = c_q;
      2'd3:    code_s = d_q;
      default: code_s = a_q;
    endcase
    an_d  = 4'hF;
    seg_d = SEG_OFF;
    if (slot_s == SLOT_SHOW && !hide_s[2'd3 - idx_q]) begin
      an_d  = ~(4'b1000 >> idx_q);
      seg_d = pat_s;
    end else begin
      an_d  = 4'hF;
      seg_d = SEG_OFF;
    end
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      a_q     <= 4'h0;
      b_q     <= 4'h0;
      c_q     <= 4'h0;
      d_q     <= 4'h0;
      blank_q <= 4'hF;
      an_q    <= 4'hF;
      seg_q   <= SEG_OFF;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      blank_q <= blank_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = 1'b1;
  assign frame = frame_q;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the Basys3 four-digit seven-segment display. It consumes the per-digit 4-bit codes A, B, C, D and the 4-bit blank mask produced by the game's message and countdown blocks. It scans one digit at a time at a fixed refresh rate and decodes each code to active-low segment patterns. Inputs are captured once per frame so a mid-frame change in the source never tears the displayed word.

## Interface
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range 4..2^20.
- GUARD, 2: cycles at the start of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV.
- BLINK_DIV, 25000000: cycles per blink half-period; only used with SEG_BLINK_EN.
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset.
- A  in  4  code for the leftmost digit (anode an[3]).
- B  in  4  code for digit an[2].
- C  in  4  code for digit an[1].
- D  in  4  code for the rightmost digit (an[0]).
- blank  in  4  per-digit blank mask; bit3 = A … bit0 = D; 1 = digit dark.
- blink  in  4  per-digit blink enable, same bit order; present only with SEG_BLINK_EN.
- an  out  4  anode enables, active low.
- seg  out  7  {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point, active low; always 1 (off).
- frame  out  1  one-cycle pulse when a new frame snapshot is taken.

## Operation
- Prescaler cnt counts 0..REFRESH_DIV-1 and wraps. Digit index idx (0=A,1=B,2=C,3=D) advances on wrap; 3 wraps to 0.
- Snapshot: when idx wraps 3→0, and on the first cycle after reset deasserts, register A, B, C, D, blank (and blink) into frame latches. Pulse frame for that cycle. Between snapshots, input changes have no effect.
- Slot states: GUARD while cnt < GUARD, with an=1111 and seg=7F. SHOW otherwise, with an = one-hot-low at idx (idx0→1110 shifted to bit3, i.e. A→0111, B→1011, C→1101, D→1110).
- In SHOW, if the latched blank bit for idx is 1, then an=1111 and seg=7F (digit fully dark, anode off).
- Code map: 0–9 are standard digits (5 doubles as S, 9 as g). A=r, B=d, C=y, D=E, E=t, F=o. So "rdy" = {blank A, A,B,C}, "SEt" = {blank, 5,D,E}, "go" = {blank, blank, 9,F}.
- Reset (reset=0): cnt=0, idx=0, latches = codes 0 with blank=1111, an=1111, seg=7F, dp=1, frame=0. Reset asserted mid-slot forces these values on the next edge.

## Timing
- an, seg, dp and frame are registered: they reflect the cnt/idx/latch state with 1 cycle latency.
- A new input word is visible at most 4·REFRESH_DIV + 1 cycles after it is applied.
- Slot length is exactly REFRESH_DIV cycles; frame period is 4·REFRESH_DIV cycles; frame pulses are exactly that far apart.
- First frame pulse: cycle 1 after reset release. Digit A SHOW begins at cycle GUARD+1.
- Input change on the same edge as the snapshot: the new value is captured.

## Configuration
- SEG_BLINK_EN defined: adds the blink port and a free-running blink counter with period 2·BLINK_DIV and phase bit ph (reset 0). When ph=1, any digit whose latched blink bit is 1 is treated as blanked. The counter is cleared by reset only.
- Not defined: no blink port, no counter; behaviour is exactly as above.

## Structure
- Package seg_pkg holds the code constants (CODE_R=4'hA, CODE_D=4'hB, CODE_Y=4'hC, CODE_E=4'hD, CODE_T=4'hE, CODE_O=4'hF), SEG_OFF=7'h7F, and the 16-entry segment pattern constants.
- Sub-module seg7_decode: purely combinational 4-bit code → 7-bit active-low pattern, instantiated once on the muxed latched code.

## Test plan
Bench parameters: REFRESH_DIV=8, GUARD=2.
- Reset held 3 cycles -> an=1111, seg=7F, dp=1, frame=0 throughout; first frame pulse 1 cycle after release.
- A,B,C,D=1,2,3,4, blank=0000 -> an sequence 0111/1011/1101/1110, each low for 6 cycles after 2 off cycles. seg for digit 1 = 7'b1111001.
- A..D=0,A,B,C, blank=1000 -> an[3] never low; the three lit slots show r, d, y patterns.
- Change D from 4 to 7 mid-frame (idx=1) -> D slot still shows 4 this frame; shows 7 in the next frame after the frame pulse.
- reset pulsed low during a SHOW slot -> next cycle an=1111, seg=7F, idx restarts at A.
- With SEG_BLINK_EN, BLINK_DIV=64, blink=0001 -> the D slot alternates lit/dark every 64 cycles; A–C unaffected.
